// File: rtl/motor_drive_pwm_if.sv
// Bus between the line-following motor logic and the H-bridge power stage.
// The master side (motor logic / bench) issues direction and enable requests.
// The slave side (motor_drive_pwm) returns bridge pins and per-motor busy flags.
interface motor_drive_pwm_if;
  logic [3:0] motor_in;  // [3:2] motor A, [1:0] motor B direction request
  logic [1:0] motor_en;  // [1] motor A, [0] motor B enable
  logic [3:0] hb_in;     // H-bridge direction pins, same mapping as motor_in
  logic [1:0] hb_pwm;    // H-bridge enable/PWM pins, [1] A, [0] B
  logic [1:0] busy;      // high while the motor sits in its dead period

  modport master (
    output motor_in,
    output motor_en,
    input  hb_in,
    input  hb_pwm,
    input  busy
  );

  modport slave (
    input  motor_in,
    input  motor_en,
    output hb_in,
    output hb_pwm,
    output busy
  );
endinterface

// File: rtl/motor_drive_pwm.sv
// Two-channel H-bridge driver.
// Each motor has its own input synchronizer, soft-start duty ramp and dead-time FSM.
// Both motors share one free-running PWM carrier.
// All outputs are registered from next-state values, so they change on the same
// edge as the FSM transition.
module motor_drive_pwm #(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_DIV    = 1000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic              clk,
  input  logic              rst_n,
  motor_drive_pwm_if.slave  bus
);

  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int DEAD_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

  localparam logic [PWM_BITS-1:0] DUTY_TOP  = PWM_BITS'(DUTY_MAX);
  localparam logic [RAMP_W-1:0]   RAMP_LAST = RAMP_W'(RAMP_DIV - 1);
  localparam logic [DEAD_W-1:0]   DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RAMP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DEAD = 2'd3;

  // Two-stage synchronizer for the asynchronous request inputs.
  logic [3:0] dir_s1_q, dir_s2_q;
  logic [1:0] en_s1_q, en_s2_q;

  // Bring the requests into the clock domain; only the second stage is used downstream.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_s1_q <= '0;
      dir_s2_q <= '0;
      en_s1_q  <= '0;
      en_s2_q  <= '0;
    end else begin
      dir_s1_q <= bus.motor_in;
      dir_s2_q <= dir_s1_q;
      en_s1_q  <= bus.motor_en;
      en_s2_q  <= en_s1_q;
    end
  end

  // Shared PWM carrier.
  logic [PWM_BITS-1:0] cnt_q, cnt_d;

  // The carrier free-runs and wraps naturally at its full width.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
  end

  // Register the carrier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [1:0]          req_dir;
      logic                req_valid;
      logic [1:0]          state_q, state_d;
      logic [1:0]          dir_q, dir_d;
      logic [PWM_BITS-1:0] duty_q, duty_d;
      logic [RAMP_W-1:0]   step_q, step_d;
      logic [DEAD_W-1:0]   dead_q, dead_d;
      logic [1:0]          hb_q, hb_d;
      logic                pwm_q, pwm_d;
      logic                busy_q, busy_d;
      logic                drive;

      // Only 01 and 10 are drive codes; 00 and 11 are stop requests.
      assign req_dir   = dir_s2_q[2*gi +: 2];
      assign req_valid = en_s2_q[gi] && ((req_dir == 2'b01) || (req_dir == 2'b10));

      // Per-motor FSM: soft-start ramp, steady run, and forced dead time before any restart.
      always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        duty_d  = duty_q;
        step_d  = step_q;
        dead_d  = dead_q;
        case (state_q)
          ST_IDLE: begin
            duty_d = '0;
            if (req_valid) begin
              state_d = ST_RAMP;
              dir_d   = req_dir;
              step_d  = '0;
            end
          end
          ST_RAMP, ST_RUN: begin
            // A stop or reversal always wins over a ramp step on the same edge.
            if (!req_valid || (req_dir != dir_q)) begin
              state_d = ST_DEAD;
              duty_d  = '0;
              step_d  = '0;
              dead_d  = '0;
            end else if (state_q == ST_RAMP) begin
              if (duty_q >= DUTY_TOP) begin
                // Covers a zero run duty: leave the ramp without stepping.
                state_d = ST_RUN;
                duty_d  = DUTY_TOP;
              end else if (step_q == RAMP_LAST) begin
                step_d = '0;
                duty_d = duty_q + 1'b1;
                if (duty_d == DUTY_TOP) state_d = ST_RUN;
              end else begin
                step_d = step_q + 1'b1;
              end
            end
          end
          ST_DEAD: begin
            // The timer runs to completion regardless of request changes.
            duty_d = '0;
            if (dead_q == DEAD_LAST) begin
              dead_d = '0;
              if (req_valid) begin
                state_d = ST_RAMP;
                dir_d   = req_dir;
                step_d  = '0;
              end else begin
                state_d = ST_IDLE;
              end
            end else begin
              dead_d = dead_q + 1'b1;
            end
          end
          default: begin
            state_d = ST_IDLE;
            duty_d  = '0;
          end
        endcase

        drive  = (state_d == ST_RAMP) || (state_d == ST_RUN);
        hb_d   = drive ? dir_d : 2'b00;
        pwm_d  = drive && (cnt_d < duty_d);
        busy_d = (state_d == ST_DEAD);
      end

      // Channel state and registered bridge outputs; reset forces the bridge off at once.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= ST_IDLE;
          dir_q   <= 2'b00;
          duty_q  <= '0;
          step_q  <= '0;
          dead_q  <= '0;
          hb_q    <= 2'b00;
          pwm_q   <= 1'b0;
          busy_q  <= 1'b0;
        end else begin
          state_q <= state_d;
          dir_q   <= dir_d;
          duty_q  <= duty_d;
          step_q  <= step_d;
          dead_q  <= dead_d;
          hb_q    <= hb_d;
          pwm_q   <= pwm_d;
          busy_q  <= busy_d;
        end
      end

      assign bus.hb_in[2*gi +: 2] = hb_q;
      assign bus.hb_pwm[gi]       = pwm_q;
      assign bus.busy[gi]         = busy_q;
    end
  endgenerate

endmodule

// File: doc/motor_drive_pwm.md
# motor_drive_pwm

Downstream power stage for the rover motor controller: consumes the per-motor direction code and enable produced by the line-following motor logic and drives the two H-bridges. Each motor gets:
- a 2-flop input synchronizer,
- a soft-start duty ramp into a shared PWM carrier,
- an enforced dead-time (both bridge inputs low, PWM off) on any stop or direction reversal, so the bridge never sees an abrupt full-duty reversal.

Both motor channels are identical and independent; only the PWM carrier counter is shared.

## Interface
- PWM_BITS, 8, width of PWM carrier counter and duty registers
- DUTY_MAX, 200, run duty; must be ≤ 2^PWM_BITS−1
- RAMP_DIV, 1000, clocks per +1 duty step during ramp; must be ≥ 1
- DEAD_CYCLES, 500, clocks of forced off-time on stop or reversal; must be ≥ 1
- clk  input  1  system clock, the single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- motor_in  input  4  requested direction; [3:2] motor A, [1:0] motor B; per motor 2'b01/2'b10 = drive, 2'b00/2'b11 = stop request
- motor_en  input  2  [1] motor A enable, [0] motor B enable
- hb_in  output  4  H-bridge direction pins, same bit mapping as motor_in
- hb_pwm  output  2  H-bridge enable/PWM pins, [1] A, [0] B
- busy  output  2  per-motor: 1 while in DEAD state

## Operation
- motor_in and motor_en pass through two flops. Only the synchronized values ("req") are used.
- Per motor, req is valid when en=1 and dir ∈ {01, 10}.
- Carrier: cnt (PWM_BITS) free-runs 0..2^PWM_BITS−1 and wraps.
- hb_pwm = (state ∈ {RAMP, RUN}) && (cnt < duty), registered.
- Per-motor FSM:
  - IDLE: duty=0, hb_in pair=00, hb_pwm=0. Valid req → RAMP; latch dir; duty=0; clear step timer.
  - RAMP: hb_in pair = latched dir. Step timer counts 0..RAMP_DIV−1; at RAMP_DIV−1, duty+1. When duty reaches DUTY_MAX → RUN.
  - RUN: duty held at DUTY_MAX.
  - In RAMP or RUN:
    - req invalid → DEAD.
    - valid req with dir ≠ latched → DEAD.
    - valid req with the same dir → no effect.
  - DEAD: hb_in pair=00, hb_pwm=0, duty=0, busy=1, dead timer counts DEAD_CYCLES clocks. On expiry:
    - valid req → RAMP with the currently requested dir (latched at that moment);
    - otherwise → IDLE.
  - Req changes during DEAD do not restart or extend the timer.
- Duty arithmetic is unsigned and saturates at DUTY_MAX; it never wraps.
- Channels A and B never interact, except through the shared carrier.

## Timing
- Reset (async assert): hb_in=0000, hb_pwm=00, busy=00, both FSMs IDLE, cnt=0, duty=0, all timers 0. Outputs go low immediately on assert. Release takes effect at the next rising edge.
- Input-to-FSM latency: 2 clocks (sync). hb_in updates 1 clock after the FSM transition, so a req change shows on hb_in at cycle 3.
- Ramp length: DUTY_MAX×RAMP_DIV clocks from RAMP entry to RUN.
- DEAD lasts exactly DEAD_CYCLES clocks of hb_in pair=00. The new dir appears on the first cycle after that.
- Simultaneous stop and reversal on the same edge: take DEAD (single dead period).
- A reversal arriving on the ramp step edge: the transition to DEAD wins; the duty increment is discarded.
- DUTY_MAX = 0: RAMP exits to RUN immediately; hb_pwm stays 0.

## Test plan
Bench parameters: PWM_BITS=4, DUTY_MAX=8, RAMP_DIV=4, DEAD_CYCLES=6.
- Reset: pulse rst_n low mid-cycle with motor_en=11 → all outputs 0 asynchronously; IDLE held while motor_en=00.
- Forward start: motor_in=0110, motor_en=11 → hb_in=0110 at cycle 3. Duty reaches 8 after 32 clocks. In RUN, hb_pwm high 8 of every 16 clocks.
- Reversal A in RUN: motor_in 0110→1010 → hb_in[3:2]=00 and busy[1]=1 for 6 clocks, then hb_in[3:2]=10 and ramp restarts from duty 0. Motor B is unaffected throughout.
- Disable mid-ramp: motor_en 11→01 at duty 3 → motor A goes DEAD for 6 clocks, then IDLE; hb_pwm[1]=0 throughout.
- Invalid code: motor_in[1:0]=11 with en=1 in RUN → motor B goes DEAD, then IDLE. Restoring 10 during DEAD resumes RAMP at DEAD expiry, not earlier.
- Async reset in RUN: rst_n low → hb_pwm=00 and hb_in=0000 the same instant. After release with a valid req held, motor starts from RAMP at duty 0.
